// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the CPU control sequencer: opcodes, step states,
// instruction classes and the packed control-strobe bundle.
package control_sequencer_pkg;

    localparam int OPC_W = 5;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        T0      = 4'd1,
        T1      = 4'd2,
        T2      = 4'd3,
        T3      = 4'd4,
        T4      = 4'd5,
        T5      = 4'd6,
        T6      = 4'd7,
        T7      = 4'd8,
        S_HALT  = 4'd9
    } state_t;

    typedef struct packed {
        logic ld;
        logic ldi;
        logic st;
        logic alu;
        logic addi;
        logic br;
        logic halt;
        logic nop;
    } iclass_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_t;

    // Field order matches the output concatenation in control_sequencer (MSB first).
    typedef struct packed {
        logic ramwrite;
        logic ramread;
        logic alu_or;
        logic alu_and;
        logic alu_sub;
        logic alu_add;
        logic outportin;
        logic inportout;
        logic conin;
        logic cout;
        logic baout;
        logic rout;
        logic rin;
        logic grc;
        logic grb;
        logic gra;
        logic loout;
        logic hiout;
        logic loin;
        logic hiin;
        logic zhighout;
        logic zhighin;
        logic zlowout;
        logic zlowin;
        logic yin;
        logic irin;
        logic mdmuxread;
        logic mdrout;
        logic mdrin;
        logic marin;
        logic incpc;
        logic pcin;
        logic pcout;
    } ctrl_t;

    function automatic logic is_run(state_t s);
        return (s != S_RESET) && (s != S_HALT);
    endfunction

endpackage

// File: rtl/control_sequencer_instr_decode.sv
// Opcode to one-hot instruction class; anything unlisted is treated as nop.
module instr_decode
    import control_sequencer_pkg::*;
#(
    parameter int OP_W = OPC_W
) (
    input  logic [OP_W-1:0] opcode,
    output iclass_t         iclass,
    output alu_op_t         alu_op
);

    always_comb begin
        iclass = '0;
        alu_op = ALU_ADD;
        case (opcode)
            OP_W'(OP_LD):   iclass.ld   = 1'b1;
            OP_W'(OP_LDI):  iclass.ldi  = 1'b1;
            OP_W'(OP_ST):   iclass.st   = 1'b1;
            OP_W'(OP_ADD):  iclass.alu  = 1'b1;
            OP_W'(OP_SUB):  begin iclass.alu = 1'b1; alu_op = ALU_SUB; end
            OP_W'(OP_AND):  begin iclass.alu = 1'b1; alu_op = ALU_AND; end
            OP_W'(OP_OR):   begin iclass.alu = 1'b1; alu_op = ALU_OR;  end
            OP_W'(OP_ADDI): iclass.addi = 1'b1;
            OP_W'(OP_BR):   iclass.br   = 1'b1;
            OP_W'(OP_HALT): iclass.halt = 1'b1;
            default:        iclass.nop  = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer for the single-bus CPU: fetch T0..T2, execute T3..T7.
// Build option MEM_WAIT_EN adds mem_ready and stretches memory steps until it is seen.
//
// state   | meaning
// S_RESET | held in clear, all strobes 0
// T0..T2  | instruction fetch (PC->MAR, mem->MDR, MDR->IR)
// T3..T7  | execute, decoded from the latched opcode
// S_HALT  | stopped, all strobes 0, left only through clear
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int OP_MSB = 31,
    parameter int OP_W   = OPC_W
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        ConFFQ,
    input  logic        stop,
`ifdef MEM_WAIT_EN
    input  logic        mem_ready,
`endif
    output logic        run,
    output logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, IRin, Yin,
    output logic        Zlowin, Zlowout, Zhighin, Zhighout, HIin, LOin, HIout, LOout,
    output logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, InPortout, OutPortin,
    output logic        ADD, SUB, AND, OR,
    output logic        RAMread, RAMwrite
);

    state_t           state, state_nxt, boundary;
    logic [OP_W-1:0]  opcode_q, opcode_sel;
    iclass_t          iclass;
    alu_op_t          alu_op;
    ctrl_t            c;
    logic             stall;
    logic             unused_ir;

    assign unused_ir = ^IR;

    // T2 must already know whether the new instruction is a nop, before the opcode is latched.
    assign opcode_sel = (state == T2) ? IR[OP_MSB -: OP_W] : opcode_q;

    instr_decode #(.OP_W(OP_W)) u_decode (
        .opcode (opcode_sel),
        .iclass (iclass),
        .alu_op (alu_op)
    );

    always_ff @(posedge clock) begin
        if (!clear) begin
            state    <= S_RESET;
            opcode_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == T2) opcode_q <= IR[OP_MSB -: OP_W];
        end
    end

    always_comb begin
        c = '0;
        case (state)
            T0: begin c.pcout = 1'b1; c.marin = 1'b1; c.incpc = 1'b1; c.zlowin = 1'b1; end
            T1: begin
                c.zlowout = 1'b1; c.pcin = 1'b1; c.ramread = 1'b1;
                c.mdmuxread = 1'b1; c.mdrin = 1'b1;
            end
            T2: begin c.mdrout = 1'b1; c.irin = 1'b1; end
            T3: begin
                if (iclass.br) begin
                    c.gra = 1'b1; c.rout = 1'b1; c.conin = 1'b1;
                end else if (iclass.alu || iclass.addi) begin
                    c.grb = 1'b1; c.rout = 1'b1; c.yin = 1'b1;
                end else if (iclass.ld || iclass.ldi || iclass.st) begin
                    c.grb = 1'b1; c.baout = 1'b1; c.yin = 1'b1;
                end
            end
            T4: begin
                if (iclass.alu) begin
                    c.grc = 1'b1; c.rout = 1'b1; c.zlowin = 1'b1;
                    c.alu_add = (alu_op == ALU_ADD);
                    c.alu_sub = (alu_op == ALU_SUB);
                    c.alu_and = (alu_op == ALU_AND);
                    c.alu_or  = (alu_op == ALU_OR);
                end else if (iclass.br) begin
                    c.pcout = 1'b1; c.yin = 1'b1;
                end else if (iclass.ld || iclass.ldi || iclass.st || iclass.addi) begin
                    c.cout = 1'b1; c.alu_add = 1'b1; c.zlowin = 1'b1;
                end
            end
            T5: begin
                if (iclass.ld || iclass.st) begin
                    c.zlowout = 1'b1; c.marin = 1'b1;
                end else if (iclass.ldi || iclass.alu || iclass.addi) begin
                    c.zlowout = 1'b1; c.gra = 1'b1; c.rin = 1'b1;
                end else if (iclass.br) begin
                    c.cout = 1'b1; c.alu_add = 1'b1; c.zlowin = 1'b1;
                end
            end
            T6: begin
                if (iclass.ld) begin
                    c.ramread = 1'b1; c.mdmuxread = 1'b1; c.mdrin = 1'b1;
                end else if (iclass.st) begin
                    c.gra = 1'b1; c.rout = 1'b1; c.mdrin = 1'b1;
                end else if (iclass.br) begin
                    c.zlowout = 1'b1; c.pcin = ConFFQ;
                end
            end
            T7: begin
                if (iclass.ld) begin
                    c.mdrout = 1'b1; c.gra = 1'b1; c.rin = 1'b1;
                end else if (iclass.st) begin
                    c.ramwrite = 1'b1;
                end
            end
            default: c = '0;
        endcase
    end

`ifdef MEM_WAIT_EN
    assign stall = (c.ramread || c.ramwrite) && !mem_ready;
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        boundary  = stop ? S_HALT : T0;
        state_nxt = state;
        case (state)
            S_RESET: state_nxt = T0;
            T0:      state_nxt = T1;
            T1:      state_nxt = T2;
            T2:      state_nxt = iclass.nop ? boundary : T3;
            T3:      state_nxt = iclass.halt ? S_HALT : T4;
            T4:      state_nxt = T5;
            T5:      state_nxt = (iclass.ldi || iclass.alu || iclass.addi) ? boundary : T6;
            T6:      state_nxt = iclass.br ? boundary : T7;
            T7:      state_nxt = boundary;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_RESET;
        endcase
        if (stall) state_nxt = state;
    end

    assign run = is_run(state);

    assign {RAMwrite, RAMread, OR, AND, SUB, ADD, OutPortin, InPortout, CONin, Cout, BAout,
            Rout, Rin, Grc, Grb, Gra, LOout, HIout, LOin, HIin, Zhighout, Zhighin, Zlowout,
            Zlowin, Yin, IRin, MDMuxread, MDRout, MDRin, MARin, IncPC, PCin, PCout} = c;

endmodule
